rs_kes_ibm: RTL and testbench

- Key-equation solver for a t=2 Reed-Solomon decoder over GF(2^8).
- Sits between the syndrome stage and the Chien/Forney stage.
- Takes four syndromes S0..S3 and runs the inversionless Berlekamp-Massey algorithm, updating Omega alongside Lambda.
- Delivers error-locator Lambda(x), deg ≤2, and error-evaluator Omega(x), deg ≤1, after a fixed 4 iterations. The iteration datapath is clock-gated when the block is idle.

---
 rtl/gf_pkg.sv | 24 ++
 rtl/clk_gate.sv | 19 +
 rtl/gf2m8_mul.sv | 22 ++
 rtl/rs_kes_ibm.sv | 167 ++++++++++++++++
 tb/tb_rs_kes_ibm.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf_pkg.sv
// GF(2^8) constants and FSM encodings shared by the
// Reed-Solomon t=2 key-equation solver.
package gf_pkg;
  localparam int SYM_W = 8;
  localparam int T = 2;
  localparam int NCOEF = 2 * T;
  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam logic [NCOEF*SYM_W-1:0] POLY_ONE =
    (NCOEF*SYM_W)'(1);

  localparam int B_IDLE = 0;
  localparam int B_IT0 = 1;
  localparam int B_IT1 = 2;
  localparam int B_IT2 = 3;
  localparam int B_IT3 = 4;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_IT0  = 5'b00010,
    ST_IT1  = 5'b00100,
    ST_IT2  = 5'b01000,
    ST_IT3  = 5'b10000
  } kes_state_e;
endpackage

// File: rtl/clk_gate.sv
// Latch-based glitch-free clock gate; the enable
// only passes while clk is low.
module clk_gate (
  input  logic clk,
  input  logic ena,
  input  logic rstn,
  output logic gclk
);
  logic ena_l;

  always_latch begin
    if (!rstn)
      ena_l = 1'b0;
    else if (!clk)
      ena_l = ena;
  end

  assign gclk = clk & ena_l;
endmodule

// File: rtl/gf2m8_mul.sv
// Combinational GF(2^8) multiplier: carry-less
// product, then reduction by GF_POLY.
module gf2m8_mul
  import gf_pkg::*;
(
  input  logic [SYM_W-1:0] x,
  input  logic [SYM_W-1:0] y,
  output logic [SYM_W-1:0] z
);
  logic [2*SYM_W-2:0] p;

  always_comb begin
    p = '0;
    for (int i = 0; i < SYM_W; i++)
      if (y[i])
        p = p ^ ((2*SYM_W-1)'(x) << i);
    for (int b = 2*SYM_W-2; b >= SYM_W; b--)
      if (p[b])
        p = p ^ ((2*SYM_W-1)'(GF_POLY) << (b - SYM_W));
    z = p[SYM_W-1:0];
  end
endmodule

// File: rtl/rs_kes_ibm.sv
// Inversionless Berlekamp-Massey key-equation solver,
// t=2, tracking Omega alongside Lambda over 4 steps.
module rs_kes_ibm
  import gf_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             kes_ena,
  input  logic [SYM_W-1:0] rs_syn0,
  input  logic [SYM_W-1:0] rs_syn1,
  input  logic [SYM_W-1:0] rs_syn2,
  input  logic [SYM_W-1:0] rs_syn3,
  output logic [SYM_W-1:0] rs_lambda0,
  output logic [SYM_W-1:0] rs_lambda1,
  output logic [SYM_W-1:0] rs_lambda2,
  output logic [SYM_W-1:0] rs_omega0,
  output logic [SYM_W-1:0] rs_omega1,
  output logic             kes_done
);
  typedef logic [NCOEF-1:0][SYM_W-1:0] poly_t;

  kes_state_e state, state_nxt;
  logic init, busy, cap, gclk, swap;
  logic [1:0] k;
  logic [2:0] l, l_nxt;
  logic [SYM_W-1:0] gam, delta;
  logic [SYM_W-1:0] dp [10];
  poly_t syn, lam, omg, b, c;
  poly_t lam_nxt, omg_nxt, dsum;
  poly_t gl, db, go, dc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    unique case (1'b1)
      state[B_IDLE]: state_nxt = kes_ena ? ST_IT0 : ST_IDLE;
      state[B_IT0]:  state_nxt = ST_IT1;
      state[B_IT1]:  state_nxt = ST_IT2;
      state[B_IT2]:  state_nxt = ST_IT3;
      state[B_IT3]:  state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    init = 1'b0;
    busy = 1'b0;
    cap = 1'b0;
    k = 2'd0;
    unique case (1'b1)
      state[B_IDLE]: init = kes_ena;
      state[B_IT0]:  begin busy = 1'b1; k = 2'd0; end
      state[B_IT1]:  begin busy = 1'b1; k = 2'd1; end
      state[B_IT2]:  begin busy = 1'b1; k = 2'd2; end
      state[B_IT3]:  begin
        busy = 1'b1;
        k = 2'd3;
        cap = 1'b1;
      end
      default: ;
    endcase
  end

  clk_gate u_cg (
    .clk  (clk),
    .ena  (init | busy),
    .rstn (rstn),
    .gclk (gclk)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      syn <= '0;
    else if (init)
      syn <= {rs_syn3, rs_syn2, rs_syn1, rs_syn0};
  end

  // Delta products for every K, packed triangularly.
  for (genvar gk = 0; gk < NCOEF; gk++) begin : g_dk
    for (genvar gi = 0; gi <= gk; gi++) begin : g_di
      gf2m8_mul u_mul (
        .x (lam[gi]),
        .y (syn[gk-gi]),
        .z (dp[gk*(gk+1)/2+gi])
      );
    end
  end

  always_comb begin
    dsum = '0;
    for (int kk = 0; kk < NCOEF; kk++)
      for (int i = 0; i <= kk; i++)
        dsum[kk] = dsum[kk] ^ dp[kk*(kk+1)/2+i];
  end

  assign delta = dsum[k] ^ omg[k];

  for (genvar gi = 0; gi < NCOEF; gi++) begin : g_up
    gf2m8_mul u_gl (.x(gam), .y(lam[gi]), .z(gl[gi]));
    gf2m8_mul u_db (.x(delta), .y(b[gi]), .z(db[gi]));
    gf2m8_mul u_go (.x(gam), .y(omg[gi]), .z(go[gi]));
    gf2m8_mul u_dc (.x(delta), .y(c[gi]), .z(dc[gi]));
    assign lam_nxt[gi] = gl[gi] ^ db[gi];
    assign omg_nxt[gi] = go[gi] ^ dc[gi];
  end

  assign swap = (delta != '0) &&
                ({l, 1'b0} <= {2'b00, k});
  assign l_nxt = {1'b0, k} + 3'd1 - l;

  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      lam <= '0;
      omg <= '0;
      b <= '0;
      c <= '0;
      gam <= '0;
      l <= '0;
    end else if (init) begin
      lam <= POLY_ONE;
      omg <= '0;
      b <= '0;
      c <= POLY_ONE;
      gam <= SYM_W'(1);
      l <= '0;
    end else begin
      lam <= lam_nxt;
      omg <= omg_nxt;
      if (swap) begin
        b <= {lam[NCOEF-2:0], {SYM_W{1'b0}}};
        c <= {omg[NCOEF-2:0], {SYM_W{1'b0}}};
        gam <= delta;
        l <= l_nxt;
      end else begin
        b <= {b[NCOEF-2:0], {SYM_W{1'b0}}};
        c <= {c[NCOEF-2:0], {SYM_W{1'b0}}};
      end
    end
  end

  // Outputs take the final step's results directly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rs_lambda0 <= '0;
      rs_lambda1 <= '0;
      rs_lambda2 <= '0;
      rs_omega0 <= '0;
      rs_omega1 <= '0;
      kes_done <= 1'b0;
    end else begin
      kes_done <= cap;
      if (cap) begin
        rs_lambda0 <= lam_nxt[0];
        rs_lambda1 <= lam_nxt[1];
        rs_lambda2 <= lam_nxt[2];
        rs_omega0 <= omg_nxt[0];
        rs_omega1 <= omg_nxt[1];
      end
    end
  end
endmodule

// File: tb/tb_rs_kes_ibm.sv
// Directed and randomized checks for rs_kes_ibm,
// its GF multiplier and the clock-gate cell.
module tb_rs_kes_ibm;
  logic clk, rstn, kes_ena, kes_done;
  logic [7:0] syn0, syn1, syn2, syn3;
  logic [7:0] lam0, lam1, lam2, omg0, omg1;
  logic [39:0] outs;
  logic [7:0] mx, my, mz;
  logic cg_ena, cg_rstn, cg_gclk;
  int cg_edges = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string name;
    logic [31:0] syn;
    logic [39:0] exp;
  } vec_t;
  vec_t tbl[4];

  rs_kes_ibm dut (
    .clk        (clk),
    .rstn       (rstn),
    .kes_ena    (kes_ena),
    .rs_syn0    (syn0),
    .rs_syn1    (syn1),
    .rs_syn2    (syn2),
    .rs_syn3    (syn3),
    .rs_lambda0 (lam0),
    .rs_lambda1 (lam1),
    .rs_lambda2 (lam2),
    .rs_omega0  (omg0),
    .rs_omega1  (omg1),
    .kes_done   (kes_done)
  );

  gf2m8_mul u_mul (.x(mx), .y(my), .z(mz));

  clk_gate u_cg (
    .clk  (clk),
    .ena  (cg_ena),
    .rstn (cg_rstn),
    .gclk (cg_gclk)
  );

  assign outs = {lam0, lam1, lam2, omg0, omg1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge cg_gclk) cg_edges++;

  function automatic logic [7:0] gmul(
    input logic [7:0] a, input logic [7:0] bb);
    logic [7:0] r, x, y;
    r = 8'h00;
    x = a;
    y = bb;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) r = r ^ x;
      y = y >> 1;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] gpow(
    input logic [7:0] a, input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < n; i++) r = gmul(r, a);
    return r;
  endfunction

  task automatic chk(input string nm,
    input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [31:0] s);
    {syn0, syn1, syn2, syn3} = s;
    kes_ena = 1'b1;
    @(negedge clk);
    kes_ena = 1'b0;
  endtask

  task automatic run(input logic [31:0] s,
    output logic [39:0] res, output int first,
    output int cnt);
    start(s);
    first = 0;
    cnt = 0;
    res = '0;
    for (int cy = 1; cy <= 8; cy++) begin
      if (kes_done === 1'b1) begin
        cnt++;
        if (first == 0) begin
          first = cy;
          res = outs;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [39:0] res;
    logic [39:0] got [3];
    logic [17:0] mask;
    logic [7:0] sv [4];
    logic [7:0] e1, e2, x1, x2, l0, l1, l2, o0, o1;
    int first, cnt, bad, p1, p2, nres;

    rstn = 1'b0;
    kes_ena = 1'b0;
    {syn0, syn1, syn2, syn3} = '0;
    cg_rstn = 1'b0;
    cg_ena = 1'b1;
    mx = 8'h00;
    my = 8'h00;
    tbl[0] = '{"zero", 32'h00000000, 40'h0100000000};
    tbl[1] = '{"err1", 32'h01020408, 40'h0102000100};
    tbl[2] = '{"err1b", 32'h030C30C0, 40'h0F3C001100};
    tbl[3] = '{"err2", 32'h00030509, 40'h050F0A000F};

    repeat (2) @(negedge clk);
    chk("rst_outs", 64'(outs), 64'h0);
    chk("rst_done", 64'(kes_done), 64'h0);
    rstn = 1'b1;

    mx = 8'h02; my = 8'h80; #1;
    chk("mul_02_80", 64'(mz), 64'h1D);
    mx = 8'h03; my = 8'h03; #1;
    chk("mul_03_03", 64'(mz), 64'h05);
    mx = 8'h01; my = 8'hA7; #1;
    chk("mul_01_a7", 64'(mz), 64'hA7);
    mx = 8'h00; my = 8'hFF; #1;
    chk("mul_00_ff", 64'(mz), 64'h00);
    bad = 0;
    for (int a = 0; a < 256; a++)
      for (int bb = 0; bb < 256; bb++) begin
        mx = 8'(a);
        my = 8'(bb);
        #1;
        if (mz !== gmul(mx, my)) bad++;
      end
    chk("mul_exh", 64'(bad), 64'h0);

    @(negedge clk);
    @(posedge clk); #1;
    chk("cg_rst", 64'(cg_gclk), 64'h0);
    @(negedge clk);
    cg_rstn = 1'b1;
    cg_ena = 1'b0;
    @(posedge clk); #1;
    chk("cg_off", 64'(cg_gclk), 64'h0);
    cg_ena = 1'b1;
    #2;
    chk("cg_glitch", 64'(cg_gclk), 64'h0);
    cg_ena = 1'b0;
    @(posedge clk); #1;
    chk("cg_pulse", 64'(cg_gclk), 64'h0);
    @(negedge clk);
    cg_ena = 1'b1;
    @(posedge clk); #1;
    chk("cg_on", 64'(cg_gclk), 64'h1);
    cg_ena = 1'b0;
    #2;
    chk("cg_hold", 64'(cg_gclk), 64'h1);
    @(negedge clk); #1;
    chk("cg_low", 64'(cg_gclk), 64'h0);
    @(posedge clk); #1;
    chk("cg_off2", 64'(cg_gclk), 64'h0);
    chk("cg_edges", 64'(cg_edges), 64'h1);
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run(tbl[i].syn, res, first, cnt);
      chk({tbl[i].name, "_out"}, 64'(res), 64'(tbl[i].exp));
      chk({tbl[i].name, "_lat"}, {32'(first), 32'(cnt)},
          {32'd5, 32'd1});
    end

    // Start request and new syndromes while busy.
    start(tbl[1].syn);
    first = 0;
    cnt = 0;
    res = '0;
    for (int cy = 1; cy <= 12; cy++) begin
      if (kes_done === 1'b1) begin
        cnt++;
        if (first == 0) begin
          first = cy;
          res = outs;
        end
      end
      if (cy == 2) begin
        {syn0, syn1, syn2, syn3} = tbl[2].syn;
        kes_ena = 1'b1;
      end
      if (cy == 3) kes_ena = 1'b0;
      @(negedge clk);
    end
    chk("busy_out", 64'(res), 64'(tbl[1].exp));
    chk("busy_lat", {32'(first), 32'(cnt)},
        {32'd5, 32'd1});

    // kes_ena held high: back-to-back runs.
    {syn0, syn1, syn2, syn3} = tbl[1].syn;
    kes_ena = 1'b1;
    @(negedge clk);
    mask = '0;
    nres = 0;
    for (int cy = 1; cy <= 17; cy++) begin
      if (kes_done === 1'b1) begin
        mask[cy] = 1'b1;
        if (nres < 3) got[nres] = outs;
        nres++;
      end
      if (cy == 1) {syn0, syn1, syn2, syn3} = tbl[2].syn;
      if (cy == 6) {syn0, syn1, syn2, syn3} = tbl[3].syn;
      if (cy == 11) kes_ena = 1'b0;
      @(negedge clk);
    end
    chk("b2b_mask", 64'(mask), 64'h08420);
    chk("b2b_run0", 64'(got[0]), 64'(tbl[1].exp));
    chk("b2b_run1", 64'(got[1]), 64'(tbl[2].exp));
    chk("b2b_run2", 64'(got[2]), 64'(tbl[3].exp));

    // Reset during IT2.
    start(tbl[2].syn);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_outs", 64'(outs), 64'h0);
    chk("mid_rst_done", 64'(kes_done), 64'h0);
    chk("mid_rst_state", 64'(dut.state), 64'h01);
    @(negedge clk);
    rstn = 1'b1;
    cnt = 0;
    for (int cy = 0; cy < 8; cy++) begin
      if (kes_done === 1'b1) cnt++;
      @(negedge clk);
    end
    chk("mid_rst_nodone", 64'(cnt), 64'h0);
    run(tbl[2].syn, res, first, cnt);
    chk("post_rst_out", 64'(res), 64'(tbl[2].exp));

    // Random two-error patterns.
    for (int n = 0; n < 1000; n++) begin
      p1 = int'($urandom_range(254, 0));
      p2 = int'($urandom_range(254, 0));
      while (p2 == p1) p2 = int'($urandom_range(254, 0));
      e1 = 8'($urandom_range(255, 1));
      e2 = 8'($urandom_range(255, 1));
      x1 = gpow(8'h02, p1);
      x2 = gpow(8'h02, p2);
      for (int j = 0; j < 4; j++)
        sv[j] = gmul(e1, gpow(x1, j)) ^ gmul(e2, gpow(x2, j));
      run({sv[0], sv[1], sv[2], sv[3]}, res, first, cnt);
      {l0, l1, l2, o0, o1} = res;
      chk("rnd_lat", {32'(first), 32'(cnt)},
          {32'd5, 32'd1});
      chk("rnd_lam", 64'({l0 != 8'h00, l1, l2}),
          64'({1'b1, gmul(l0, x1 ^ x2),
               gmul(l0, gmul(x1, x2))}));
      chk("rnd_omg", 64'({o0, o1}),
          64'({gmul(l0, sv[0]),
               gmul(l0, sv[1] ^ gmul(x1 ^ x2, sv[0]))}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
